// File: rtl/cpu_pkg.sv
// Types and defaults shared by the CPU pipeline stages.
package cpu_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h1c000000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } ibuf_entry_t;

    function automatic logic [31:0] next_pc(input logic [31:0] addr);
        return addr + 32'd4;
    endfunction

endpackage

// File: rtl/ibuf_fifo.sv
// Synchronous FIFO with single-cycle flush; head data is read combinationally.
module ibuf_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW:0]      count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (reset || flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_en) begin
                mem_d[wr_ptr_q] = wr_data;
                wr_ptr_d        = wr_ptr_q + PW'(1);
            end
            if (rd_en) rd_ptr_d = rd_ptr_q + PW'(1);
            // Simultaneous write and read cancel out in the count.
            count_d = count_q + (PW+1)'(wr_en) - (PW+1)'(rd_en);
        end
    end

    always_ff @(posedge clk) begin
        mem_q    <= mem_d;
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        count_q  <= count_d;
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign empty   = (count_q == '0);
    assign count   = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding SRAM request, small instruction buffer,
// redirect flushes the buffer and drops the in-flight response.
module fetch_unit import cpu_pkg::*; #(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int          IBUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        inst_sram_en,
    output logic [3:0]  inst_sram_we,
    output logic [31:0] inst_sram_addr,
    output logic [31:0] inst_sram_wdata,
    input  logic [31:0] inst_sram_rdata,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        ds_allowin,
    output logic        fs_valid,
    output logic [31:0] fs_pc,
    output logic [31:0] fs_inst
);
    localparam int CW = $clog2(IBUF_DEPTH) + 1;

    logic [31:0]   pc_q, pc_d, req_pc_q, req_pc_d;
    logic          inflight_q, inflight_d;
    logic [CW-1:0] ibuf_count, occupancy;
    logic          ibuf_empty, ibuf_wr, pop;
    ibuf_entry_t   wr_entry, head;

    assign inst_sram_we    = 4'b0;
    assign inst_sram_wdata = 32'b0;
    assign inst_sram_addr  = br_taken ? br_target : pc_q;

    assign fs_valid = ~reset & ~ibuf_empty;
    assign pop      = fs_valid & ds_allowin & ~br_taken;

    // Slots already claimed once this cycle's pop and write settle; a new
    // request is only safe if its response will still find room.
    assign occupancy    = ibuf_count + CW'(inflight_q) - CW'(pop);
    assign inst_sram_en = ~reset & (br_taken | (occupancy < CW'(IBUF_DEPTH)));

    // A redirect in the response cycle means the response is stale.
    assign ibuf_wr  = inflight_q & ~br_taken & ~reset;
    assign wr_entry = '{pc: req_pc_q, inst: inst_sram_rdata};

    always_comb begin
        pc_d       = pc_q;
        req_pc_d   = req_pc_q;
        inflight_d = inst_sram_en;
        if (reset) begin
            pc_d = RESET_PC;
        end else if (inst_sram_en) begin
            pc_d     = next_pc(inst_sram_addr);
            req_pc_d = inst_sram_addr;
        end
    end

    always_ff @(posedge clk) begin
        pc_q       <= pc_d;
        req_pc_q   <= req_pc_d;
        inflight_q <= inflight_d;
    end

    ibuf_fifo #(
        .DEPTH (IBUF_DEPTH),
        .WIDTH ($bits(ibuf_entry_t))
    ) u_ibuf (
        .clk     (clk),
        .reset   (reset),
        .flush   (br_taken),
        .wr_en   (ibuf_wr),
        .wr_data (wr_entry),
        .rd_en   (pop),
        .rd_data (head),
        .empty   (ibuf_empty),
        .count   (ibuf_count)
    );

    assign fs_pc   = head.pc;
    assign fs_inst = head.inst;

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h1c000000, address of the first fetch after reset.
REQ-002 SHALL have parameter IBUF_DEPTH, default 2, instruction-buffer entries; power of two, at least 2.
REQ-003 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port inst_sram_en  output  1  fetch request this cycle.
REQ-006 SHALL have port inst_sram_we  output  4  constant 4'b0.
REQ-007 SHALL have port inst_sram_addr  output  32  fetch address.
REQ-008 SHALL have port inst_sram_wdata  output  32  constant 32'b0.
REQ-009 SHALL have port inst_sram_rdata  input  32  read data, valid exactly one cycle after its request.
REQ-010 SHALL have port br_taken  input  1  redirect request from a later stage.
REQ-011 SHALL have port br_target  input  32  redirect address, word-aligned by contract.
REQ-012 SHALL have port ds_allowin  input  1  decode accepts fs_pc/fs_inst this cycle.
REQ-013 SHALL have port fs_valid  output  1  fs_pc/fs_inst hold a valid instruction.
REQ-014 SHALL have port fs_pc  output  32  PC of the buffer head.
REQ-015 SHALL have port fs_inst  output  32  instruction of the buffer head.

Function
REQ-016 SHALL keep register pc, the next sequential fetch address.
REQ-017 SHALL drive inst_sram_addr = br_taken ? br_target : pc, combinationally.
REQ-018 SHALL assert inst_sram_en when not in reset and either br_taken=1 or (count + inflight - pop) < IBUF_DEPTH, where pop = fs_valid & ds_allowin & ~br_taken.
REQ-019 SHALL, on an issued request, load pc <= inst_sram_addr + 4; with no request, pc holds.
REQ-020 SHALL track one in-flight request (inflight bit). The bit is set in the cycle after an issued request.
REQ-021 SHALL write {addr, inst_sram_rdata} into the buffer tail in the cycle after the request, unless that request was cancelled.
REQ-022 SHALL give latency: request in cycle T, fs_valid=1 with that instruction in cycle T+2 at the earliest.
REQ-023 SHALL drive fs_valid = buffer non-empty, with fs_pc/fs_inst taken from the head entry; the head is removed at the clock edge where pop=1.
REQ-024 SHALL sustain one instruction per cycle when ds_allowin=1 continuously and no redirect occurs.
REQ-025 SHALL hold the head stable while fs_valid=1 and ds_allowin=0, and SHALL issue no request that could overflow the buffer.
REQ-026 SHALL, on br_taken=1: flush all buffer entries, cancel the response of any earlier in-flight request, and issue br_target in the same cycle.
REQ-027 SHALL give redirect precedence over pop in the same cycle; the head is discarded and does not count as consumed.
REQ-028 SHALL, on back-to-back redirects, keep only the latest; responses to earlier redirects are dropped.
REQ-029 SHALL use wrap-around pointers of log2(IBUF_DEPTH) bits and a count of log2(IBUF_DEPTH)+1 bits; a simultaneous write and pop leaves the count unchanged.
REQ-030 SHALL let pc arithmetic wrap modulo 2^32, with no exception.

Reset
REQ-031 SHALL, in reset, set pc=RESET_PC, count=0, pointers=0 and inflight=0, and drive fs_valid=0 and inst_sram_en=0.
REQ-032 SHALL issue the first request, addr=RESET_PC, in the first cycle after reset deasserts, subject to REQ-018.
REQ-033 SHALL, on reset asserted mid-operation, discard buffered and in-flight data; no stale instruction appears after reset.

Structure
REQ-034 SHALL take RESET_PC default and the ibuf entry type {pc[31:0], inst[31:0]} from the shared cpu package.
REQ-035 SHALL instantiate one sub-module, ibuf_fifo: a synchronous FIFO with flush, parameterised by depth and entry width.

Verification
REQ-036 SHALL verify: reset release, ds_allowin=1, SRAM returns addr as data -> fs_pc 1c000000, 1c000004, 1c000008 in consecutive cycles, first one 2 cycles after the first request.
REQ-037 SHALL verify: IBUF_DEPTH=2, ds_allowin=0 for 10 cycles -> exactly 2 entries buffered, inst_sram_en=0, head stays 1c000000; release -> order preserved, no gap.
REQ-038 SHALL verify: br_taken=1 with target 1c000100 while 1c000008 is in flight -> 1c000008 never presented, next fs_pc=1c000100, then 1c000104.
REQ-039 SHALL verify: redirect and pop in the same cycle, buffer full -> flush, head not counted as consumed, fs_valid=0 for 1 cycle, then 1c000100.
REQ-040 SHALL verify: redirects in two consecutive cycles (1c000200 then 1c000300) -> only 1c000300 stream appears.
REQ-041 SHALL verify: reset asserted with 2 entries buffered and 1 in flight -> fs_valid=0 in the next cycle, and refetch starts at 1c000000.
